// File: rtl/aidc_lite_pkg.sv
// AIDC-Lite shared types and constants.
// Used by the decompression reassembly buffer.
package aidc_lite_pkg;

  localparam int AIDC_BLK_WORDS = 16;
  localparam int AIDC_WORD_W    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } buf_state_t;

endpackage

// File: rtl/aidc_lite_buf_mem.sv
// Block word store with per-entry written mask.
// Unwritten entries read back as zero.
module aidc_lite_buf_mem
  import aidc_lite_pkg::*;
#(
  parameter int NUM_ENTRIES = AIDC_BLK_WORDS,
  parameter int DATA_W      = AIDC_WORD_W,
  localparam int AW         = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0]      mem_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      mask_q <= '0;
    end else if (we_i) begin
      mask_q[waddr_i] <= 1'b1;
    end
  end

  // Mask hides stale words left over from earlier blocks.
  assign rdata_o = mask_q[raddr_i] ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/aidc_lite_decomp_buf.sv
// AIDC-Lite decompression reassembly buffer.
// Collects a block of writes, then drains it in order.
module aidc_lite_decomp_buf
  import aidc_lite_pkg::*;
#(
  parameter int NUM_DECOMP  = 4,
  parameter int NUM_ENTRIES = AIDC_BLK_WORDS,
  parameter int DATA_W      = AIDC_WORD_W,
  localparam int SW         = $clog2(NUM_DECOMP),
  localparam int AW         = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [SW-1:0]         sel_i,
  output logic                  start_ready_o,
  input  logic                  wr_valid_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [NUM_DECOMP-1:0] done_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_last_o,
  output logic                  err_o
);

  buf_state_t        state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              err_q, err_d;
  logic              clr, we, done_sel, hs;
  logic [DATA_W-1:0] rdata;

  assign done_sel      = done_i[sel_q];
  assign start_ready_o = (state_q == IDLE);
  assign out_valid_o   = (state_q == DRAIN);
  assign out_last_o    = out_valid_o &&
                         (ptr_q == AW'(NUM_ENTRIES-1));
  assign out_data_o    = out_valid_o ? rdata : '0;
  assign hs            = out_valid_o && out_ready_i;
  assign err_o         = err_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    clr     = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_valid_i) err_d = 1'b1;
        if (start_i) begin
          sel_d   = sel_i;
          clr     = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        we = wr_valid_i;
        // done must already have dropped after sop
        if (done_sel) err_d = 1'b1;
        state_d = FILL;
      end
      FILL: begin
        we = wr_valid_i;
        if (done_sel) begin
          ptr_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_valid_i) err_d = 1'b1;
        if (hs) begin
          ptr_d = ptr_q + 1'b1;
          if (out_last_o) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  aidc_lite_buf_mem #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .DATA_W      (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .we_i    (we),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (ptr_q),
    .rdata_o (rdata)
  );

endmodule
